// File: rtl/ucore_dispatch.sv
// ucore_dispatch
//   Shares one microcoded core among NREQ requesters. A round-robin arbiter
//   picks a job in IDLE, the operand is latched onto core_in, the core is
//   launched with a one-cycle core_start pulse, and the result (or a timeout
//   abort) is returned to the winning requester.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. Requests: req_valid[i] with req_ready[i]; req_ready is one-hot on
//   the arbitration winner and only asserted in IDLE. Responses: rsp_valid[g]
//   with rsp_ready[g]; rsp_valid/rsp_data/rsp_err stay stable until the
//   transfer, and rsp_ready bits of other requesters are ignored.
//
// Ports
//   clk        clock, rising edge
//   aresetn    asynchronous active-low reset
//   req_valid  [NREQ]     per-requester job request
//   req_data   [NREQ*DW]  per-requester operand, slice i = [i*DW +: DW]
//   req_ready  [NREQ]     one-hot job accept (combinational, IDLE only)
//   rsp_valid  [NREQ]     one-hot result valid
//   rsp_data   [DW]       shared result
//   rsp_err    1          timeout flag, qualified by rsp_valid
//   rsp_ready  [NREQ]     per-requester result accept
//   core_in    [DW]       operand to the core, held until the next grant
//   core_start 1          one-cycle launch pulse
//   core_done  1          core completion, sampled only in WAIT
//   core_out   [DW]       core result, valid with core_done
//   state_dbg  [2]        current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 RESPOND)
module ucore_dispatch #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [DW-1:0]      core_in,
  output logic               core_start,
  input  logic               core_done,
  input  logic [DW-1:0]      core_out,
  output logic [1:0]         state_dbg
);

  localparam int GW  = $clog2(NREQ);
  localparam int CW  = GW + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int TW1 = TW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   win_idx;
  logic            win_found;
  logic [CW-1:0]   cand;
  logic [TW-1:0]   timer;
  logic [TW1-1:0]  timer_inc;
  logic            timeout_hit;
  logic            rsp_fire;

  // Round-robin search: candidates last_grant+1, +2, ... with wrap. The
  // extra bit in cand holds the unwrapped sum so one subtraction suffices.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, last_grant} + CW'(k + 1);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!win_found && req_valid[cand[GW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[GW-1:0];
      end
    end
  end

  // timer holds the number of WAIT cycles already finished, so timer+1 is
  // the count including the current one; the abort fires on the TIMEOUT-th
  // WAIT cycle and the counter never exceeds TIMEOUT.
  assign timer_inc   = {1'b0, timer} + TW1'(1);
  assign timeout_hit = (timer_inc == TW1'(TIMEOUT));
  assign rsp_fire    = (state == S_RESPOND) && rsp_ready[grant];
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    case (state)
      S_IDLE: begin
        // Gated by aresetn so every output reads zero while reset is held.
        if (win_found && aresetn) begin
          req_ready[win_idx] = 1'b1;
          state_nx           = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_start = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (core_done || timeout_hit) state_nx = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid[grant] = 1'b1;
        if (rsp_fire) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      core_in    <= '0;
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      timer      <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            core_in <= req_data[int'(win_idx)*DW +: DW];
            grant   <= win_idx;
          end
        end
        S_LAUNCH: timer <= '0;
        S_WAIT: begin
          // Completion has priority over a timeout in the same cycle.
          if (core_done) begin
            rsp_data <= core_out;
            rsp_err  <= 1'b0;
          end else begin
            timer <= timer_inc[TW-1:0];
            if (timeout_hit) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end
          end
        end
        S_RESPOND: begin
          if (rsp_fire) last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucore_dispatch.sv
// Testbench for ucore_dispatch (NREQ=4, DW=32, TIMEOUT=8).
// Table of directed jobs, an abandoned job cut by reset, then random jobs
// predicted by a round-robin reference model and an expected-response queue.
module tb_ucore_dispatch;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 8;

  logic               clk;
  logic               aresetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic [NREQ-1:0]    rsp_ready;
  logic [DW-1:0]      core_in;
  logic               core_start;
  logic               core_done;
  logic [DW-1:0]      core_out;
  logic [1:0]         state_dbg;

  ucore_dispatch #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .core_in    (core_in),
    .core_start (core_start),
    .core_done  (core_done),
    .core_out   (core_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Expected response word: {rsp_err, rsp_valid[3:0], rsp_data[31:0]}
  logic [36:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_last = NREQ - 1;
  logic [31:0] op[NREQ];

  typedef struct {
    logic [3:0]  rv;          // req_valid at the grant cycle
    logic [3:0]  rv_after;    // req_valid held while the job is in flight
    int          done_after;  // WAIT cycles before core_done (>=TIMEOUT or <0: never)
    logic [31:0] cout;        // core result
    int          ready_delay; // cycles rsp_ready[grant] stays low
    int          exp_g;       // expected winner
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Round-robin reference: first requester after 'last', wrapping around.
  function automatic int rr_pick(input int last, input logic [3:0] rv);
    for (int k = 1; k <= NREQ; k++) begin
      if (rv[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ*DW-1:0] pack_ops();
    return {op[3], op[2], op[1], op[0]};
  endfunction

  // ---------------- driver ----------------
  task automatic do_job(input vec_t v);
    logic [3:0]  oh;
    logic [36:0] exp_w;
    logic [36:0] got_w;
    logic [36:0] held;
    int          n_wait;
    bit          done_ok;
    oh      = 4'b0001 << v.exp_g;
    done_ok = (v.done_after >= 0) && (v.done_after < TIMEOUT);
    n_wait  = done_ok ? v.done_after + 1 : TIMEOUT;
    exp_w   = done_ok ? {1'b0, oh, v.cout} : {1'b1, oh, 32'h0};
    exp_q.push_back(exp_w);

    // grant cycle (IDLE)
    @(negedge clk);
    rsp_ready = '0;
    core_done = 1'b0;
    req_valid = v.rv;
    req_data  = pack_ops();
    #1;
    check("idle_state", 64'({state_dbg, rsp_valid, core_start}), 64'(0));
    check("grant_ready", 64'(req_ready), 64'(oh));

    // LAUNCH: a stray core_done here must be ignored; operand inputs change
    @(negedge clk);
    req_valid = v.rv_after;
    req_data  = ~req_data;
    core_done = 1'b1;
    core_out  = 32'hDEAD_BEEF;
    #1;
    check("launch_start", 64'({core_start, req_ready, rsp_valid}), 64'({1'b1, 8'h00}));
    check("launch_core_in", 64'(core_in), 64'(op[v.exp_g]));

    // WAIT
    for (int w = 1; w <= n_wait; w++) begin
      @(negedge clk);
      core_done = done_ok && (w == v.done_after + 1);
      core_out  = core_done ? v.cout : $urandom;
      #1;
      check("wait_quiet", 64'({core_start, rsp_valid, req_ready}), 64'(0));
      check("wait_core_in", 64'(core_in), 64'(op[v.exp_g]));
    end

    // RESPOND
    @(negedge clk);
    core_done = 1'b0;
    core_out  = $urandom;
    rsp_ready = ~oh;
    if (v.ready_delay == 0) rsp_ready = 4'b1111;
    #1;
    got_w = {rsp_err, rsp_valid, rsp_data};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL response: got %h expected <empty queue>", got_w);
    end else begin
      check("response", 64'(got_w), 64'(exp_q.pop_front()));
    end
    check("respond_no_grant", 64'({req_ready, core_start}), 64'(0));
    held = got_w;
    for (int d = 0; d < v.ready_delay; d++) begin
      @(negedge clk);
      if (d == v.ready_delay - 1) rsp_ready = 4'b1111;
      #1;
      check("rsp_stable", 64'({rsp_err, rsp_valid, rsp_data}), 64'(held));
      check("bp_quiet", 64'({req_ready, core_start}), 64'(0));
    end
    model_last = v.exp_g;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t rv_vec;
    int   g;

    aresetn   = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = '0;
    core_done = 1'b0;
    core_out  = '0;

    vecs[0]  = '{4'b1111, 4'b1111,  0, 32'hA000_0000,  0, 0};
    vecs[1]  = '{4'b1111, 4'b1111,  0, 32'hA000_0001,  0, 1};
    vecs[2]  = '{4'b1111, 4'b1111,  0, 32'hA000_0002,  0, 2};
    vecs[3]  = '{4'b1111, 4'b1111,  0, 32'hA000_0003,  0, 3};
    vecs[4]  = '{4'b1111, 4'b1111,  0, 32'hA000_0004,  0, 0};
    vecs[5]  = '{4'b0001, 4'b0000,  5, 32'hCAFE_F00D,  0, 0};
    vecs[6]  = '{4'b0010, 4'b0000, -1, 32'h0000_0000,  0, 1};
    vecs[7]  = '{4'b0100, 4'b1011,  2, 32'h0BAD_CAFE, 10, 2};
    vecs[8]  = '{4'b1011, 4'b0000,  7, 32'h5A5A_0001,  1, 3};
    vecs[9]  = '{4'b1010, 4'b1010,  0, 32'h1212_1212,  2, 1};
    vecs[10] = '{4'b1001, 4'b0000,  3, 32'h3434_3434,  0, 3};
    vecs[11] = '{4'b0110, 4'b0000,  8, 32'h7777_7777,  0, 1};

    // reset state, with requests already pending
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, core_start, state_dbg}), 64'(0));
    check("reset_data", 64'({core_in, rsp_data}), 64'(0));
    @(negedge clk);
    req_valid = '0;
    aresetn   = 1'b1;

    // directed table
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NREQ; r++) op[r] = $urandom;
      op[0] = 32'h1234_5678;
      do_job(vecs[i]);
    end

    // job abandoned by reset in WAIT
    for (int r = 0; r < NREQ; r++) op[r] = $urandom;
    g = rr_pick(model_last, 4'b1111);
    @(negedge clk);
    rsp_ready = '0;
    req_valid = 4'b1111;
    req_data  = pack_ops();
    #1;
    check("abort_grant", 64'(req_ready), 64'(4'b0001 << g));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    check("midjob_reset_ctrl", 64'({req_ready, rsp_valid, rsp_err, core_start, state_dbg}), 64'(0));
    check("midjob_reset_data", 64'({core_in, rsp_data}), 64'(0));
    repeat (2) @(negedge clk);
    aresetn    = 1'b1;
    model_last = NREQ - 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("no_stale_rsp", 64'({rsp_valid, core_start, state_dbg}), 64'(0));
    end
    for (int r = 0; r < NREQ; r++) op[r] = $urandom;
    rv_vec = '{4'b1111, 4'b0000, 1, 32'h600D_0000, 0, 0};
    do_job(rv_vec);

    // random jobs against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < NREQ; r++) op[r] = $urandom;
      rv_vec.rv          = 4'($urandom_range(1, 15));
      rv_vec.rv_after    = 4'($urandom_range(0, 15));
      rv_vec.done_after  = $urandom_range(0, 9);
      rv_vec.cout        = $urandom;
      rv_vec.ready_delay = $urandom_range(0, 3);
      rv_vec.exp_g       = rr_pick(model_last, rv_vec.rv);
      do_job(rv_vec);
    end

    @(negedge clk);
    rsp_ready = '0;
    req_valid = '0;
    #1;
    check("final_idle", 64'({state_dbg, rsp_valid, core_start}), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
